// File: rtl/fix_mul_arb.sv
// Round-robin arbiter in front of a shared two-stage signed fixed-point multiplier.
// Results return in acceptance order with a one-hot owner tag.
module fix_mul_arb #(
  parameter int N_REQ      = 4,
  parameter int INT_BITS   = 12,
  parameter int FRAC_BITS  = 4,
  parameter int TOTAL_BITS = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*TOTAL_BITS-1:0] req_a,
  input  logic [N_REQ*TOTAL_BITS-1:0] req_b,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [TOTAL_BITS-1:0]       rsp_data,
  output logic                        rsp_ovf,
  output logic                        busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int W  = INT_BITS + FRAC_BITS;

  logic [IW-1:0]          last_grant;
  logic [IW-1:0]          gidx;
  logic [N_REQ-1:0]       grant;
  logic                   found;
  logic [TOTAL_BITS-1:0]  sel_a;
  logic [TOTAL_BITS-1:0]  sel_b;
  logic                   xfer;

  logic                   s1_valid;
  logic [IW-1:0]          s1_owner;
  logic signed [W-1:0]    s1_a;
  logic signed [W-1:0]    s1_b;

  logic signed [2*W-1:0]  full;
  logic signed [2*W-1:0]  shifted;
  logic [W:0]             hi;
  logic                   ovf;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    sel_a = '0;
    sel_b = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      automatic int idx = (int'(last_grant) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = IW'(idx);
        sel_a      = req_a[idx*TOTAL_BITS +: TOTAL_BITS];
        sel_b      = req_b[idx*TOTAL_BITS +: TOTAL_BITS];
      end
    end
  end

  assign req_ready = rst_n ? grant : '0;
  assign xfer      = |req_ready;

  // The top sign-copy bits of the shifted product join the overflow check,
  // so every product bit above the result must match its sign bit.
  always_comb begin
    full    = s1_a * s1_b;
    shifted = full >>> FRAC_BITS;
    hi      = shifted[2*W-1:W-1];
    ovf     = !((&hi) || !(|hi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IW'(N_REQ-1);
      s1_valid   <= 1'b0;
      s1_owner   <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_ovf    <= 1'b0;
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        last_grant <= gidx;
        s1_owner   <= gidx;
        s1_a       <= sel_a;
        s1_b       <= sel_b;
      end
      rsp_valid <= s1_valid ? (N_REQ'(1) << s1_owner) : '0;
      if (s1_valid) begin
        rsp_data <= shifted[W-1:0];
        rsp_ovf  <= ovf;
      end
    end
  end

  assign busy = s1_valid | (|rsp_valid);

endmodule

// File: tb/tb_fix_mul_arb.sv
// Scoreboard bench for fix_mul_arb: predicts grants, products and owners,
// and checks responses in acceptance order.
module tb_fix_mul_arb;

  localparam int N  = 4;
  localparam int IB = 12;
  localparam int FB = 4;
  localparam int TW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*TW-1:0] req_a = '0;
  logic [N*TW-1:0] req_b = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [TW-1:0]   rsp_data;
  logic            rsp_ovf;
  logic            busy;

  fix_mul_arb #(
    .N_REQ(N), .INT_BITS(IB), .FRAC_BITS(FB), .TOTAL_BITS(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  own;
    logic [TW-1:0] data;
    logic          ovf;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            failures = 0;
  int            ptr;
  bit            s1_m, s2_m, g_prev;
  logic [TW-1:0] last_data;
  logic          last_ovf;
  logic [TW-1:0] opa[N];
  logic [TW-1:0] opb[N];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input int own, input logic [TW-1:0] a,
                                 input logic [TW-1:0] b);
    exp_t   e;
    longint p;
    longint s;
    p      = longint'($signed(a)) * longint'($signed(b));
    s      = p >>> FB;
    e.own  = N'(1) << own;
    e.data = s[TW-1:0];
    e.ovf  = (p >= (64'sd1 <<< (TW+FB-1))) || (p < -(64'sd1 <<< (TW+FB-1)));
    return e;
  endfunction

  task automatic cycle(input logic [N-1:0] v);
    exp_t         e;
    logic [N-1:0] exp_rv;
    logic [N-1:0] g;
    int           gi;
    @(negedge clk);
    s2_m   = s1_m;
    s1_m   = g_prev;
    exp_rv = '0;
    if (s2_m) begin
      if (q.size() == 0) begin
        chk("sb_underflow", 1, 0);
        s2_m = 0;
      end else begin
        e      = q.pop_front();
        exp_rv = e.own;
      end
    end
    chk("rsp_valid", rsp_valid, exp_rv);
    if (s2_m) begin
      chk("rsp_data", rsp_data, e.data);
      chk("rsp_ovf", rsp_ovf, e.ovf);
      last_data = e.data;
      last_ovf  = e.ovf;
    end else begin
      chk("hold_data", rsp_data, last_data);
      chk("hold_ovf", rsp_ovf, last_ovf);
    end
    chk("busy", busy, s1_m | s2_m);
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_a[i*TW +: TW] = opa[i];
      req_b[i*TW +: TW] = opb[i];
    end
    #1;
    g  = '0;
    gi = 0;
    for (int k = 1; k <= N; k++) begin
      automatic int idx = (ptr + k) % N;
      if (g == '0 && v[idx]) begin
        g[idx] = 1'b1;
        gi     = idx;
      end
    end
    chk("req_ready", req_ready, g);
    if (g != '0) begin
      q.push_back(model(gi, opa[gi], opb[gi]));
      ptr    = gi;
      g_prev = 1;
    end else begin
      g_prev = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = '1;
    rst_n     = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_ovf", rsp_ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    req_valid = '0;
    q.delete();
    s1_m = 0; s2_m = 0; g_prev = 0;
    ptr = N-1;
    last_data = '0;
    last_ovf  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_ops(input int i, input logic [TW-1:0] a,
                         input logic [TW-1:0] b);
    opa[i] = a;
    opb[i] = b;
  endtask

  initial begin
    for (int i = 0; i < N; i++) set_ops(i, 16'h0, 16'h0);
    do_reset();

    set_ops(0, 16'h0018, 16'h0020);
    cycle(4'b0001);
    cycle(4'b0000);
    set_ops(1, 16'hFFE8, 16'h0020);
    cycle(4'b0010);
    cycle(4'b0000);
    set_ops(2, 16'h7FF0, 16'h0020);
    cycle(4'b0100);
    repeat (3) cycle(4'b0000);

    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, 16'(16*(i+1)), 16'(16*(i+2)));
    repeat (8) cycle(4'b1111);
    repeat (3) cycle(4'b0000);

    set_ops(3, 16'hFFF0, 16'h8000);
    repeat (5) cycle(4'b1000);
    repeat (3) cycle(4'b0000);

    set_ops(0, 16'h0030, 16'hFFC0);
    cycle(4'b0001);
    do_reset();
    repeat (2) cycle(4'b0000);
    set_ops(0, 16'h0018, 16'h0020);
    cycle(4'b0001);
    repeat (3) cycle(4'b0000);

    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < N; i++)
        set_ops(i, 16'($urandom), 16'($urandom));
      cycle(4'($urandom_range(0, 15)));
    end
    repeat (4) cycle(4'b0000);
    chk("sb_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/fix_mul_arb.md
FIX_MUL_ARB -- requirements
Module: fix_mul_arb

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters sharing one fixed-point multiplier (2..8).
REQ-002 Parameter: INT_BITS, default 12, integer bits of the operand format.
REQ-003 Parameter: FRAC_BITS, default 4, fraction bits of the operand format.
REQ-004 Parameter: TOTAL_BITS, default 16, operand/result width; SHALL equal INT_BITS+FRAC_BITS.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 req_valid  input  N_REQ  bit i: requester i presents an operand pair.
REQ-008 req_a  input  N_REQ*TOTAL_BITS  signed operand A; slice i belongs to requester i.
REQ-009 req_b  input  N_REQ*TOTAL_BITS  signed operand B; slice i belongs to requester i.
REQ-010 req_ready  output  N_REQ  one-hot grant; combinational from req_valid and the priority pointer.
REQ-011 rsp_valid  output  N_REQ  one-hot, one-cycle pulse marking the result owner.
REQ-012 rsp_data  output  TOTAL_BITS  signed product in operand format.
REQ-013 rsp_ovf  output  1  product did not fit TOTAL_BITS; qualified by any rsp_valid bit.
REQ-014 busy  output  1  high while any accepted operation is still in the pipeline.

Function
REQ-015 A transfer SHALL occur on requester i when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-016 At most one req_ready bit SHALL be high per cycle; req_ready SHALL be all-zero when req_valid is all-zero.
REQ-017 Arbitration SHALL be round-robin: search starts at index (last_grant+1) mod N_REQ, and the first valid index wins.
REQ-018 last_grant SHALL update only on a transfer; with no transfer the pointer SHALL hold.
REQ-019 A single requester holding req_valid continuously SHALL be granted every cycle (back-to-back throughput of 1 per cycle).
REQ-020 With all N_REQ requesters valid continuously, each SHALL be granted exactly once per N_REQ cycles.
REQ-021 Stage 1 (transfer edge) SHALL register the operands and owner index; stage 2 (next edge) SHALL register the result, ovf and owner.
REQ-022 Latency: for a transfer at edge k, rsp_valid[owner] SHALL be high for exactly the cycle after edge k+1 (result visible 2 edges after acceptance).
REQ-023 Results SHALL be returned in acceptance order; there is no response backpressure and the requester SHALL sample rsp_data while its rsp_valid bit is high.
REQ-024 Arithmetic: full signed 2*TOTAL_BITS product a*b, arithmetic right shift by FRAC_BITS, low TOTAL_BITS kept (truncation toward minus infinity, wrap on overflow).
REQ-025 rsp_ovf SHALL be 1 when bits [2*TOTAL_BITS-1 : TOTAL_BITS+FRAC_BITS-1] of the full product are not all equal.
REQ-026 rsp_data and rsp_ovf SHALL hold their last values when rsp_valid is zero.
REQ-027 busy SHALL equal (stage-1 valid OR stage-2 valid).
REQ-028 A requester that drops req_valid without a grant SHALL lose nothing and SHALL leave the pointer unaffected.

Reset
REQ-029 On rst_n low, asynchronously: rsp_valid=0, rsp_data=0, rsp_ovf=0, busy=0, pipeline valids=0, last_grant=N_REQ-1 (so requester 0 has first priority).
REQ-030 Operations in flight when reset asserts SHALL be discarded and produce no rsp_valid.
REQ-031 req_ready SHALL be all-zero while rst_n is low.
REQ-032 The first transfer SHALL be possible at the first rising edge with rst_n high.

Verification
REQ-033 req0 a=0x0018 (1.5), b=0x0020 (2.0) for one cycle -> rsp_valid=0001 two edges later, rsp_data=0x0030, rsp_ovf=0.
REQ-034 req1 a=0xFFE8 (-1.5), b=0x0020 -> rsp_valid=0010, rsp_data=0xFFD0 (-3.0), rsp_ovf=0.
REQ-035 req2 a=0x7FF0 (2047.0), b=0x0020 -> rsp_data=0xFFE0, rsp_ovf=1.
REQ-036 All 4 valid for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; rsp_valid follows the same order, 2 edges later.
REQ-037 req3 alone valid for 5 cycles -> 5 consecutive grants and 5 consecutive rsp_valid=1000 pulses; busy high from the first acceptance until the last response.
REQ-038 rst_n low one cycle after a transfer -> no rsp_valid, all outputs 0; a new transfer after release returns the correct result.
